// File: rtl/gate_sweep_driver.sv
// Exhaustive stimulus/check driver for an N_IN-input combinational gate under test.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module gate_sweep_driver #(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [2**N_IN-1:0]    EXPECT = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              y_in,
  output logic [N_IN-1:0]   a_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] idx_q;
  logic [CW-1:0]   cnt_q;

  logic            mismatch;
  logic [N_IN:0]   err_inc;

  assign mismatch = (y_in != EXPECT[idx_q]);
  assign err_inc  = err_count + (N_IN+1)'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      a_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_SETTLE;
            idx_q      <= '0;
            a_out      <= '0;
            cnt_q      <= CNT_INIT;
            busy       <= 1'b1;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_SAMPLE: begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          if (mismatch) begin
            state_q    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= (N_IN+1)'(1);
            first_fail <= idx_q;
          end else
`endif
          begin
            err_count <= err_inc;
            if (mismatch && (err_count == '0)) begin
              first_fail <= idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_inc == '0);
            end else begin
              // a_out tracks idx so the gate sees the new vector for the full settle window
              idx_q   <= idx_q + 1'b1;
              a_out   <= idx_q + 1'b1;
              cnt_q   <= CNT_INIT;
              state_q <= ST_SETTLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Directed bench: default 2-input AND driver plus a 3-input, SETTLE=3 instance.
module tb_gate_sweep_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  int         gsel = 0;          // 0 = AND, 1 = OR, 2 = stuck at 0

  logic       y_in;
  logic [1:0] a_out;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_fail;

  logic       y3;
  logic [2:0] a3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] ff3;

  int checks = 0;
  int errors = 0;
  int ecnt;

  always #5 clk = ~clk;

  assign y_in = (gsel == 0) ? (&a_out) : (gsel == 1) ? (|a_out) : 1'b0;
  assign y3   = &a3;

  gate_sweep_driver dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .a_out(a_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
  );

  gate_sweep_driver #(.N_IN(3), .SETTLE(3), .EXPECT(8'b1000_0000)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .y_in(y3), .a_out(a3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_fail(ff3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, follow the sweep edge by edge, then check the final results.
  task automatic sweep(input string name, input int gs, input int restart_edge,
                       input logic exp_pass, input int exp_err, input int exp_ff,
                       input int exp_edges, input int exp_a);
    gsel  = gs;
    start = 1'b1;
    tick();
    start = 1'b0;
    ecnt  = 0;
    while (!done && ecnt < 40) begin
      chk({name, "_a_out"}, 32'(a_out), 32'(ecnt >> 1));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      start = (ecnt == restart_edge);
      tick();
      ecnt++;
    end
    start = 1'b0;
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_edges"}, 32'(ecnt), 32'(exp_edges));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({name, "_err"}, 32'(err_count), 32'(exp_err));
    chk({name, "_ff"}, 32'(first_fail), 32'(exp_ff));
    chk({name, "_a_final"}, 32'(a_out), 32'(exp_a));
    $display("sweep %s: edges=%0d pass=%0d err=%0d ff=%0d", name, ecnt, pass, err_count, first_fail);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_a_out", 32'(a_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_ff", 32'(first_fail), 0);
    chk("rst3_busy", 32'(busy3), 0);
    rst = 1'b0;
    tick();

    sweep("and", 0, -1, 1'b1, 0, 0, 8, 3);
    tick();
    chk("and_done_pulse", 32'(done), 0);
    chk("and_pass_held", 32'(pass), 1);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    sweep("or", 1, -1, 1'b0, 1, 1, 4, 1);
`else
    sweep("or", 1, -1, 1'b0, 2, 1, 8, 3);
`endif

    // start in the done cycle is accepted and clears the previous result
    gsel  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redone_busy", 32'(busy), 1);
    chk("redone_err", 32'(err_count), 0);
    chk("redone_ff", 32'(first_fail), 0);
    chk("redone_pass", 32'(pass), 0);
    chk("redone_a_out", 32'(a_out), 0);
    ecnt = 0;
    while (!done && ecnt < 40) begin
      tick();
      ecnt++;
    end
    chk("redone_edges", 32'(ecnt), 8);
    chk("redone_pass_end", 32'(pass), 1);
    $display("sweep redone: edges=%0d pass=%0d", ecnt, pass);

    sweep("stuck0", 2, 3, 1'b0, 1, 3, 8, 3);
    tick();
    chk("stuck0_no_restart", 32'(busy), 0);

    // reset mid-sweep once vector 2 is on the bus
    gsel  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_a_out", 32'(a_out), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_a_out", 32'(a_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err_count), 0);
    chk("mid_rst_done", 32'(done), 0);
    $display("reset mid-sweep: a_out=%0d busy=%0d", a_out, busy);
    tick();
    chk("mid_idle_busy", 32'(busy), 0);
    sweep("after_rst", 0, -1, 1'b1, 0, 0, 8, 3);

    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    ecnt = 0;
    while (!done3 && ecnt < 80) begin
      chk("n3_a_out", 32'(a3), 32'(ecnt >> 2));
      tick();
      ecnt++;
    end
    chk("n3_done", 32'(done3), 1);
    chk("n3_edges", 32'(ecnt), 32);
    chk("n3_pass", 32'(pass3), 1);
    chk("n3_err", 32'(err3), 0);
    chk("n3_ff", 32'(ff3), 0);
    $display("sweep n3: edges=%0d pass=%0d err=%0d", ecnt, pass3, err3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
